// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants and types for the total_alu execute-stage ALU
package alu_pkg;

    localparam int WIDTH      = 32;
    localparam int MUL_CYCLES = 32;

    // R-type funct field encodings
    localparam logic [5:0] F_SLL   = 6'd0;
    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MFLO  = 6'd18;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_ADD   = 6'd32;
    localparam logic [5:0] F_SUB   = 6'd34;
    localparam logic [5:0] F_AND   = 6'd36;
    localparam logic [5:0] F_OR    = 6'd37;
    localparam logic [5:0] F_SLT   = 6'd42;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mul_state_e;

endpackage

// File: rtl/multu_seq.sv
// rtl/multu_seq.sv - sequential shift-add unsigned multiplier, one iteration per cycle
module multu_seq
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam logic [5:0] LAST_ITER = 6'(MUL_CYCLES - 1);

    mul_state_e         state_q, state_d;
    logic [5:0]         count_q, count_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q,  prod_d;
    logic [WIDTH:0]     upper_sum;

    // Multiplier state, counter, captured multiplicand and running product
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
        end
    end

    // Next-state: capture on start, then add-and-shift keeping the adder carry-out
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        mcand_d   = mcand_q;
        prod_d    = prod_q;
        done      = 1'b0;
        upper_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]};
        if (prod_q[0]) begin
            upper_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = BUSY;
                    count_d = '0;
                    mcand_d = a;
                    // Upper half cleared; the multiplier rides in the lower half and
                    // is consumed one bit per shift as the product fills in from the top.
                    prod_d  = {{WIDTH{1'b0}}, b};
                end
            end
            BUSY: begin
                prod_d  = {upper_sum, prod_q[WIDTH-1:1]};
                count_d = count_q + 6'd1;
                if (count_q == LAST_ITER) begin
                    state_d = IDLE;
                    count_d = '0;
                    done    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The final product is presented on the same cycle done is raised
    assign hi   = prod_d[2*WIDTH-1:WIDTH];
    assign lo   = prod_d[WIDTH-1:0];
    assign busy = (state_q == BUSY);

endmodule

// File: rtl/total_alu.sv
// rtl/total_alu.sv - MIPS-style ALU with funct decode, HiLo pair and sequential MULTU
module total_alu
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [5:0]       Signal,
    output logic [WIDTH-1:0] Output
);

    logic [5:0]       prev_q;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             mul_start;
    logic [WIDTH-1:0] mul_hi, mul_lo;
    logic             mul_busy, mul_done;

    // Start only on entry into MULTU so a held funct code runs a single multiply
    assign mul_start = (Signal == F_MULTU) && (prev_q != F_MULTU) && !mul_busy;

    multu_seq u_multu (
        .clk   (clk),
        .reset (reset),
        .start (mul_start),
        .a     (dataA),
        .b     (dataB),
        .hi    (mul_hi),
        .lo    (mul_lo),
        .busy  (mul_busy),
        .done  (mul_done)
    );

    // HiLo is written only when the multiplier finishes
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (mul_done) begin
            hi_d = mul_hi;
            lo_d = mul_lo;
        end
    end

    // Previous funct code and the HiLo pair
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            prev_q <= Signal;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    // Combinational result select; MULTU and unknown codes drive zero
    always_comb begin
        Output = '0;
        case (Signal)
            F_AND:   Output = dataA & dataB;
            F_OR:    Output = dataA | dataB;
            F_ADD:   Output = dataA + dataB;
            F_SUB:   Output = dataA - dataB;
            F_SLT:   Output = {{(WIDTH-1){1'b0}}, ($signed(dataA) < $signed(dataB))};
            F_SLL:   Output = dataA << dataB[4:0];
            F_MFHI:  Output = hi_q;
            F_MFLO:  Output = lo_q;
            default: Output = '0;
        endcase
    end

endmodule

// File: tb/tb_total_alu.sv
// tb/tb_total_alu.sv - directed self-checking bench for total_alu
module tb_total_alu;

    logic        clk;
    logic        reset;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [5:0]  Signal;
    logic [31:0] Output;

    int errors = 0;
    int checks = 0;

    total_alu dut (
        .clk    (clk),
        .reset  (reset),
        .dataA  (dataA),
        .dataB  (dataB),
        .Signal (Signal),
        .Output (Output)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [5:0] sig, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        Signal = sig;
        dataA  = a;
        dataB  = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(6'd63, 32'h0, 32'h0);
    endtask

    task automatic chk(input string tag, input logic [31:0] exp);
        #1;
        checks++;
        assert (Output === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, Output, exp);
        end
    endtask

    initial begin
        reset  = 1'b1;
        Signal = 6'd63;
        dataA  = '0;
        dataB  = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state of HiLo
        drive(6'd16, 32'h1234, 32'h5678); chk("reset_mfhi", 32'h0);
        drive(6'd18, 32'h1234, 32'h5678); chk("reset_mflo", 32'h0);

        // Logic ops
        drive(6'd36, 32'hF0F0F0F0, 32'h0FF00FF0); chk("and", 32'h00F000F0);
        drive(6'd37, 32'hF0F0F0F0, 32'h0FF00FF0); chk("or",  32'hFFF0FFF0);

        // Arithmetic wrap
        drive(6'd32, 32'hFFFFFFFF, 32'd1); chk("add_wrap", 32'h0);
        drive(6'd34, 32'd5, 32'd7);        chk("sub_wrap", 32'hFFFFFFFE);
        drive(6'd32, 32'd100, 32'd23);     chk("add_small", 32'd123);

        // Signed compare and shift
        drive(6'd42, 32'hFFFFFFFF, 32'd1); chk("slt_neg_pos", 32'd1);
        drive(6'd42, 32'd1, 32'hFFFFFFFF); chk("slt_pos_neg", 32'd0);
        drive(6'd42, 32'd7, 32'd7);        chk("slt_equal",   32'd0);
        drive(6'd0, 32'd3, 32'd4);         chk("sll_4",       32'd48);
        drive(6'd0, 32'd1, 32'd35);        chk("sll_mask",    32'd8);

        // Unknown code
        drive(6'd63, 32'hFFFFFFFF, 32'hFFFFFFFF); chk("unknown_zero", 32'h0);

        // Full-scale multiply, held 33 cycles
        drive(6'd25, 32'hFFFFFFFF, 32'hFFFFFFFF); chk("multu_out_zero", 32'h0);
        for (int i = 1; i < 33; i++) drive(6'd25, 32'hFFFFFFFF, 32'hFFFFFFFF);
        idle(2);
        drive(6'd16, 32'h0, 32'h0); chk("max_mfhi", 32'hFFFFFFFE);
        drive(6'd18, 32'h0, 32'h0); chk("max_mflo", 32'h00000001);
        drive(6'd16, 32'h0, 32'h0); chk("max_mfhi_reread", 32'hFFFFFFFE);

        // Operands changing during BUSY are ignored
        drive(6'd25, 32'd123456, 32'd654321);
        for (int i = 1; i < 33; i++) drive(6'd25, 32'hDEADBEEF, 32'hCAFEF00D);
        idle(2);
        drive(6'd16, 32'h0, 32'h0); chk("mid_mfhi", 32'd18);
        drive(6'd18, 32'h0, 32'h0); chk("mid_mflo", 32'd3470442048);

        // Held 40 cycles: one multiply; operand change after completion must not restart
        drive(6'd25, 32'd0, 32'd5);
        for (int i = 1; i < 35; i++) drive(6'd25, 32'd0, 32'd5);
        for (int i = 35; i < 40; i++) drive(6'd25, 32'd3, 32'd3);
        idle(40);
        drive(6'd16, 32'h0, 32'h0); chk("zero_mfhi", 32'h0);
        drive(6'd18, 32'h0, 32'h0); chk("zero_mflo", 32'h0);

        // Signal leaves MULTU after one cycle: multiply still completes
        drive(6'd25, 32'd6, 32'd11);
        idle(40);
        drive(6'd18, 32'h0, 32'h0); chk("short_mflo", 32'd66);

        // Reset mid-multiply aborts and clears HiLo
        drive(6'd25, 32'd7, 32'd9);
        for (int i = 1; i < 10; i++) drive(6'd25, 32'd7, 32'd9);
        drive(6'd18, 32'h0, 32'h0);
        reset = 1'b1;
        chk("reset_async_mflo", 32'h0);
        @(negedge clk);
        reset = 1'b0;
        idle(40);
        drive(6'd16, 32'h0, 32'h0); chk("abort_mfhi", 32'h0);
        drive(6'd18, 32'h0, 32'h0); chk("abort_mflo", 32'h0);

        // Fresh multiply after reset
        drive(6'd25, 32'd7, 32'd9);
        for (int i = 1; i < 33; i++) drive(6'd25, 32'd7, 32'd9);
        idle(2);
        drive(6'd18, 32'h0, 32'h0); chk("fresh_mflo", 32'd63);
        drive(6'd16, 32'h0, 32'h0); chk("fresh_mfhi", 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
